// File: rtl/rr_stream_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package rr_stream_arbiter_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  // Maps a search offset relative to base back to a requester index (mod n).
  function automatic int unsigned rr_rotate(input int unsigned base,
                                            input int unsigned offs,
                                            input int unsigned n);
    int unsigned s;
    s = base + offs;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr, wrapping.
module rr_priority_pick
  import rr_stream_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] idx
);

  logic [ID_WIDTH-1:0] sel;

  // Scan from the farthest offset down so the closest request to ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sel   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sel = ID_WIDTH'(rr_rotate(32'(ptr), 32'(k), 32'(NUM_REQ)));
      if (req[sel]) begin
        found = 1'b1;
        idx   = sel;
      end
    end
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Packet-locking round-robin arbiter feeding one registered valid/ready output stage.
module rr_stream_arbiter
  import rr_stream_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]                  req_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_last,
  output logic [ID_WIDTH-1:0]                 out_id
);

  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] lock_id_q, lock_id_d;
  logic                pick_found;
  logic [ID_WIDTH-1:0] pick_idx;
  logic                grant_vld;
  logic [ID_WIDTH-1:0] grant_id;
  logic                stage_free;
  logic                xfer;

  rr_priority_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign stage_free = !out_valid || out_ready;

  // While locked the grant stays on lock_id even if that requester idles.
  always_comb begin
    grant_vld = (state_q == ARB_LOCKED) || pick_found;
    grant_id  = (state_q == ARB_LOCKED) ? lock_id_q : pick_idx;
  end

  assign xfer = grant_vld && stage_free && req_valid[grant_id];

  always_comb begin
    req_ready = '0;
    if (grant_vld && stage_free && rst_n) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

  // The pointer advances only on a last-beat transfer.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    if (xfer) begin
      if (req_last[grant_id]) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = ID_WIDTH'(rr_rotate(32'(grant_id), 32'd1, 32'(NUM_REQ)));
      end else begin
        state_d   = ARB_LOCKED;
        lock_id_d = grant_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_id    <= '0;
    end else if (stage_free) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= req_data[grant_id];
        out_last <= req_last[grant_id];
        out_id   <= grant_id;
      end
    end
  end

endmodule
